// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for the boot loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed little-endian byte image, writes 32-bit words
// into instruction memory and keeps the core in reset until the image is complete.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        LEN0, LEN1, DATA, FLUSH, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [IDX_W-1:0]  word_idx_next;

    assign accept        = bus.in_valid && in_ready_q;
    assign len_full      = {bus.in_data, len_q[7:0]};
    assign word_idx_next = word_idx_q + 1'b1;

    // Lower three byte lanes of the word being assembled; the fourth byte goes
    // straight into the write data on the completing edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        assign word_d[8*gi +: 8] = (accept && state_q == DATA && byte_idx_q == 2'(gi))
                                   ? bus.in_data : word_q[8*gi +: 8];
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            LEN0: begin
                if (accept) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d[15:8] = bus.in_data;
                    if (len_full == 16'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wdata_d    = {bus.in_data, word_q};
                        waddr_d    = word_idx_q[ADDR_W-1:0];
                        we_d       = 1'b1;
                        word_idx_d = word_idx_next;
                        if (32'(word_idx_next) == 32'(len_q))
                            state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d    = DONE;
                done_d     = 1'b1;
                core_rst_d = 1'b0;
            end
            default: ;
        endcase
        in_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LEN0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: expected writes are queued as bytes are
// accepted and matched (address, data, cycle) by a monitor on the falling edge.
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    imem_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

    // Write monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%08h cyc=%0d required no write",
                         bus.imem_waddr, bus.imem_wdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%08h cyc=%0d required addr=%0d data=%08h cyc=%0d",
                             bus.imem_waddr, bus.imem_wdata, cyc, e.addr, e.data, e.cyc);
                end else begin
                    $display("write ok addr=%0d data=%08h cyc=%0d", e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [15:0] len, input logic [31:0] words[$], input int gap);
        send_byte(len[7:0]);
        repeat (gap) begin @(posedge clk); #1; end
        send_byte(len[15:8]);
        repeat (gap) begin @(posedge clk); #1; end
        for (int k = 0; k < words.size(); k++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] w;
                w = words[k];
                send_byte(w[8*j +: 8]);
                if (j == 3) sb.push_back('{addr: 8'(k), data: w, cyc: cyc});
                if (!(k == words.size() - 1 && j == 3))
                    repeat (gap) begin @(posedge clk); #1; end
            end
        end
    endtask

    // Called right after the final byte is accepted: one FLUSH cycle, then DONE
    task automatic check_end(input string name);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.core_rst !== 1'b1) begin
            errors++;
            $display("FAIL %s_flush done=%b in_ready=%b core_rst=%b required 0 0 1",
                     name, bus.done, bus.in_ready, bus.core_rst);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.core_rst !== 1'b0 || bus.in_ready !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done=%b core_rst=%b in_ready=%b err=%b required 1 0 0 0",
                     name, bus.done, bus.core_rst, bus.in_ready, bus.err);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL %s_extra in_ready=%b done=%b required 0 1", name, bus.in_ready, bus.done);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes pending=%0d required 0", name, sb.size());
        end
        $display("%s finished", name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.core_rst !== 1'b1 || bus.done !== 1'b0 ||
                bus.imem_we !== 1'b0 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold in_ready=%b core_rst=%b done=%b we=%b err=%b required 0 1 0 0 0",
                         bus.in_ready, bus.core_rst, bus.done, bus.imem_we, bus.err);
            end
        end
        checks++;
        if (bus.imem_waddr !== '0 || bus.imem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus waddr=%0d wdata=%08h required 0 0", bus.imem_waddr, bus.imem_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.core_rst !== 1'b1 || bus.done !== 1'b0 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b core_rst=%b done=%b we=%b required 1 1 0 0",
                     bus.in_ready, bus.core_rst, bus.done, bus.imem_we);
        end
        $display("test_reset finished");
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_words(input int gap);
        logic [31:0] w[$];
        w = '{32'h00100513, 32'h00200593};
        do_reset();
        send_image(16'd2, w, gap);
        check_end(gap == 0 ? "two_words" : "two_words_gap");
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.core_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len done=%b core_rst=%b in_ready=%b required 1 0 0",
                     bus.done, bus.core_rst, bus.in_ready);
        end
        $display("test_zero_len finished");
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlength();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b1 || bus.core_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL overlength err=%b core_rst=%b in_ready=%b done=%b required 1 1 0 0",
                         bus.err, bus.core_rst, bus.in_ready, bus.done);
            end
        end
        bus.in_valid = 1'b0;
        $display("test_overlength finished");
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_depth();
        logic [31:0] w[$];
        for (int k = 0; k < 256; k++) w.push_back($urandom);
        do_reset();
        send_image(16'd256, w, 0);
        check_end("full_depth");
    endtask

    task automatic test_mid_reset();
        logic [31:0] w[$];
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h10 + i));
            if (i == 3) sb.push_back('{addr: 8'd0, data: 32'h13121110, cyc: cyc});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.core_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset core_rst=%b in_ready=%b we=%b done=%b required 1 0 0 0",
                     bus.core_rst, bus.in_ready, bus.imem_we, bus.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        w = '{32'hDDCCBBAA};
        send_image(16'd1, w, 0);
        check_end("mid_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_two_words(0);
        test_two_words(1);
        test_zero_len();
        test_overlength();
        test_full_depth();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
